// File: rtl/keypad_pkg.sv
// keypad_pkg: key codes, scanner state encoding and the 4x4 key map shared by the keypad entry block.
package keypad_pkg;
  localparam logic [3:0] KEY_A     = 4'd10;
  localparam logic [3:0] KEY_B     = 4'd11;
  localparam logic [3:0] KEY_C     = 4'd12;
  localparam logic [3:0] KEY_D     = 4'd13;
  localparam logic [3:0] KEY_STAR  = 4'd14;
  localparam logic [3:0] KEY_HASH  = 4'd15;
  localparam logic [3:0] KEY_CLEAR = KEY_C;
  localparam logic [3:0] KEY_BKSP  = KEY_STAR;
  localparam logic [3:0] KEY_ENTER = KEY_HASH;

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_e;

  // Rows 0-2 of columns 0-2 hold the digits 1-9 in reading order.
  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] base;
    base = 4'({r, 1'b0}) + 4'(r) + 4'(c) + 4'd1;
    return c == 2'd3 ? (r == 2'd0 ? KEY_A : r == 2'd1 ? KEY_B : r == 2'd2 ? KEY_C : KEY_D)
         : r != 2'd3 ? base
         : c == 2'd0 ? KEY_STAR : c == 2'd1 ? 4'd0 : KEY_HASH;
  endfunction
endpackage

// File: rtl/bcd4_to_bin.sv
// bcd4_to_bin: four packed BCD digits to their binary value (0-9999).
module bcd4_to_bin (
  input  logic [15:0] bcd_i,
  output logic [13:0] bin_o
);
  assign bin_o = 14'(bcd_i[15:12]) * 14'd1000 + 14'(bcd_i[11:8]) * 14'd100
               + 14'(bcd_i[7:4]) * 14'd10 + 14'(bcd_i[3:0]);
endmodule

// File: rtl/keypad_scan_entry.sv
// keypad_scan_entry: 4x4 keypad column scanner with debounce, plus four-digit decimal entry with enter/clear/backspace.
module keypad_scan_entry
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 100000,
  parameter int DEBOUNCE_TICKS = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  rows,
  output logic [3:0]  cols,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic [15:0] digits,
  output logic [13:0] value,
  output logic [13:0] entered_value,
  output logic        enter_pulse
);
  localparam int DW = $clog2(SCAN_DIV + 1);
  localparam int CW = $clog2(DEBOUNCE_TICKS + 1);

  logic [DW-1:0] div_q, div_d;
  logic          tick;
  logic [3:0]    rows_m_q, rows_s_q;
  state_e        state_q;
  logic [1:0]    col_q, row_q, low_row;
  logic [CW-1:0] cnt_q;
  logic          key_valid_q;
  logic [3:0]    key_code_q;
  logic [15:0]   digits_q, digits_d;
  logic [2:0]    count_q, count_d;
  logic [13:0]   entered_q, entered_d;
  logic          enter_q, enter_d;

  assign tick    = div_q == DW'(SCAN_DIV - 1);
  assign div_d   = tick ? '0 : div_q + 1'b1;
  assign low_row = !rows_s_q[0] ? 2'd0 : !rows_s_q[1] ? 2'd1 : !rows_s_q[2] ? 2'd2 : 2'd3;

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q    <= '0;
      rows_m_q <= 4'hF;
      rows_s_q <= 4'hF;
    end else begin
      div_q    <= div_d;
      rows_m_q <= rows;
      rows_s_q <= rows_m_q;
    end
  end

  // The capture tick counts as the first stable sample, so acceptance needs DEBOUNCE_TICKS lows in a row.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= SCAN;
      col_q       <= 2'd0;
      row_q       <= 2'd0;
      cnt_q       <= '0;
      key_valid_q <= 1'b0;
      key_code_q  <= 4'd0;
    end else begin
      key_valid_q <= 1'b0;
      if (tick) begin
        case (state_q)
          SCAN:
            if (rows_s_q == 4'hF) col_q <= col_q + 2'd1;
            else begin
              row_q   <= low_row;
              cnt_q   <= '0;
              state_q <= DEBOUNCE;
            end
          DEBOUNCE:
            if (rows_s_q[row_q]) state_q <= SCAN;
            else if (int'(cnt_q) + 1 >= DEBOUNCE_TICKS - 1) begin
              key_valid_q <= 1'b1;
              key_code_q  <= key_map(row_q, col_q);
              cnt_q       <= '0;
              state_q     <= HELD;
            end else cnt_q <= cnt_q + 1'b1;
          HELD:
            if (rows_s_q != 4'hF) cnt_q <= '0;
            else if (int'(cnt_q) + 1 >= DEBOUNCE_TICKS) begin
              cnt_q   <= '0;
              state_q <= SCAN;
            end else cnt_q <= cnt_q + 1'b1;
          default: state_q <= SCAN;
        endcase
      end
    end
  end

  always_comb begin
    digits_d  = digits_q;
    count_d   = count_q;
    entered_d = entered_q;
    enter_d   = 1'b0;
    if (key_valid_q) begin
      if (key_code_q <= 4'd9) begin
        if (count_q < 3'd4) begin
          digits_d = {digits_q[11:0], key_code_q};
          count_d  = count_q + 3'd1;
        end
      end else if (key_code_q == KEY_BKSP) begin
        digits_d = {4'h0, digits_q[15:4]};
        count_d  = count_q == 3'd0 ? 3'd0 : count_q - 3'd1;
      end else if (key_code_q == KEY_CLEAR) begin
        digits_d = '0;
        count_d  = '0;
      end else if (key_code_q == KEY_ENTER) begin
        entered_d = value;
        enter_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      digits_q  <= '0;
      count_q   <= '0;
      entered_q <= '0;
      enter_q   <= 1'b0;
    end else begin
      digits_q  <= digits_d;
      count_q   <= count_d;
      entered_q <= entered_d;
      enter_q   <= enter_d;
    end
  end

  bcd4_to_bin u_bcd (.bcd_i(digits_q), .bin_o(value));

  assign cols          = ~(4'b0001 << col_q);
  assign key_valid     = key_valid_q;
  assign key_code      = key_code_q;
  assign digits        = digits_q;
  assign entered_value = entered_q;
  assign enter_pulse   = enter_q;
endmodule

// File: tb/tb_keypad_scan_entry.sv
// tb_keypad_scan_entry: simulated keypad matrix driving the scanner, checked every cycle against a behavioural model.
module tb_keypad_scan_entry;
  localparam int SD = 4;
  localparam int DT = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  rows, cols, key_code;
  logic        key_valid, enter_pulse;
  logic [15:0] digits, conv_in;
  logic [13:0] value, entered_value, conv_out;
  logic [15:0] pressed = '0;
  int n_checks = 0, n_fail = 0, kv_count = 0, ep_count = 0, kv_before = 0;

  int         kmap[16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};
  logic [3:0] col_drive[4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  int         m_col, m_phase, m_row, m_stable, m_quiet, m_div, m_entered;
  logic [3:0] sh0, sh1, m_sync, m_code;
  bit         m_kv, m_ep, m_tick;
  int         dq[$];
  logic [53:0] got, want;

  keypad_scan_entry #(.SCAN_DIV(SD), .DEBOUNCE_TICKS(DT)) dut (
    .clk(clk), .reset(reset), .rows(rows), .cols(cols), .key_valid(key_valid),
    .key_code(key_code), .digits(digits), .value(value),
    .entered_value(entered_value), .enter_pulse(enter_pulse)
  );

  bcd4_to_bin u_conv (.bcd_i(conv_in), .bin_o(conv_out));

  always #5 clk = ~clk;

  // A key pulls its row low only while its column is driven low.
  always_comb begin
    rows = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && cols[c] == 1'b0) rows[r] = 1'b0;
  end

  function automatic int q_value();
    int v = 0;
    foreach (dq[i]) v = v * 10 + dq[i];
    return v;
  endfunction

  function automatic logic [15:0] q_digits();
    logic [15:0] d = '0;
    foreach (dq[i]) d = {d[11:0], 4'(dq[i])};
    return d;
  endfunction

  function automatic int pos_of(int code);
    for (int i = 0; i < 16; i++) if (kmap[i] == code) return i;
    return 0;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_col = 0; m_phase = 0; m_row = 0; m_stable = 0; m_quiet = 0; m_div = 0;
      m_entered = 0; m_kv = 0; m_ep = 0; m_code = 4'd0; sh0 = 4'hF; sh1 = 4'hF;
      dq.delete();
    end else begin
      m_ep = 0;
      if (m_kv) begin
        if (m_code <= 9) begin
          if (dq.size() < 4) dq.push_back(int'(m_code));
        end else if (m_code == 14) begin
          if (dq.size() > 0) void'(dq.pop_back());
        end else if (m_code == 12) dq.delete();
        else if (m_code == 15) begin
          m_entered = q_value();
          m_ep = 1;
        end
      end
      m_kv = 0;
      m_sync = sh1; sh1 = sh0; sh0 = rows;
      m_tick = (m_div == SD - 1);
      m_div = m_tick ? 0 : m_div + 1;
      if (m_tick) begin
        if (m_phase == 0) begin
          if (m_sync == 4'hF) m_col = (m_col + 1) % 4;
          else begin
            for (int r = 3; r >= 0; r--) if (!m_sync[r]) m_row = r;
            m_stable = 1;
            m_phase = 1;
          end
        end else if (m_phase == 1) begin
          if (m_sync[m_row]) m_phase = 0;
          else begin
            m_stable++;
            if (m_stable >= DT) begin
              m_kv = 1;
              m_code = 4'(kmap[m_row*4+m_col]);
              m_quiet = 0;
              m_phase = 2;
            end
          end
        end else begin
          if (m_sync == 4'hF) begin
            m_quiet++;
            if (m_quiet >= DT) m_phase = 0;
          end else m_quiet = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    got  = {cols, key_valid, key_code, digits, value, entered_value, enter_pulse};
    want = {col_drive[m_col], m_kv, m_code, q_digits(), 14'(q_value()), 14'(m_entered), m_ep};
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL outputs t=%0t got cols=%b kv=%b code=%0d digits=%h value=%0d ent=%0d ep=%b want cols=%b kv=%b code=%0d digits=%h value=%0d ent=%0d ep=%b",
               $time, cols, key_valid, key_code, digits, value, entered_value, enter_pulse,
               want[53:50], want[49], want[48:45], want[44:29], want[28:15], want[14:1], want[0]);
    end
  end

  always @(posedge clk) begin
    if (key_valid) kv_count++;
    if (enter_pulse) ep_count++;
  end

  task automatic check(string name, int got_v, int want_v);
    n_checks++;
    if (got_v !== want_v) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", name, got_v, want_v);
    end
  endtask

  task automatic clks(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(int code, int hold, int rel);
    pressed = 16'b1 << pos_of(code);
    clks(hold);
    pressed = '0;
    clks(rel);
  endtask

  initial begin
    clks(2);
    reset = 1'b0;
    clks(4);  check("idle_col1", int'(cols), 4'b1101);
    clks(4);  check("idle_col2", int'(cols), 4'b1011);
    clks(4);  check("idle_col3", int'(cols), 4'b0111);
    clks(4);  check("idle_col0", int'(cols), 4'b1110);
    clks(24);
    check("idle_outputs_zero", int'({key_valid, key_code, digits, value, entered_value, enter_pulse}), 0);
    check("idle_no_keys", kv_count, 0);

    pressed = 16'b1 << pos_of(5);
    clks(100);
    check("key5_one_pulse", kv_count, 1);
    check("key5_code", int'(key_code), 5);
    check("key5_cols_frozen", int'(cols), 4'b1101);
    pressed = '0;
    clks(24);
    check("key5_digits", int'(digits), 16'h0005);
    check("key5_value", int'(value), 5);

    press(12, 48, 24);
    foreach (kmap[i]) if (i < 6) press(i == 5 ? 15 : i + 1, 48, 24);
    check("entry_digits", int'(digits), 16'h1234);
    check("entry_value", int'(value), 1234);
    check("entry_entered", int'(entered_value), 1234);
    check("entry_one_enter", ep_count, 1);

    kv_before = kv_count;
    repeat (5) begin
      pressed = 16'b1 << pos_of(7);
      clks(8);
      pressed = '0;
      clks(4);
    end
    check("bounce_no_pulse", kv_count, kv_before);
    pressed = 16'b1 << pos_of(7);
    clks(40);
    pressed = '0;
    clks(24);
    check("bounce_one_pulse", kv_count, kv_before + 1);

    press(12, 48, 24);
    press(1, 48, 24);
    press(2, 48, 24);
    press(14, 48, 24);
    check("bksp_digits", int'(digits), 16'h0001);
    check("bksp_value", int'(value), 1);
    press(12, 48, 24);
    check("clear_digits", int'(digits), 0);
    press(14, 48, 24);
    check("bksp_empty_digits", int'(digits), 0);
    check("bksp_empty_value", int'(value), 0);

    press(3, 48, 24);
    pressed = 16'b1 << pos_of(9);
    for (int i = 0; i < 200 && m_phase != 1; i++) clks(1);
    check("reach_debounce", m_phase, 1);
    kv_before = kv_count;
    reset = 1'b1;
    clks(1);
    check("rst_cols", int'(cols), 4'b1110);
    check("rst_digits", int'(digits), 0);
    check("rst_entered", int'(entered_value), 0);
    clks(1);
    reset = 1'b0;
    clks(60);
    check("rst_redetect_once", kv_count, kv_before + 1);
    check("rst_redetect_code", int'(key_code), 9);
    pressed = '0;
    clks(24);

    for (int i = 0; i < 40; i++) begin
      pressed = 16'b1 << $urandom_range(0, 15);
      if ($urandom_range(0, 3) == 0) pressed[$urandom_range(0, 15)] = 1'b1;
      clks($urandom_range(2, 60));
      pressed = '0;
      clks($urandom_range(2, 40));
    end
    clks(40);

    for (int i = 0; i < 10000; i++) begin
      conv_in = {4'(i / 1000), 4'((i / 100) % 10), 4'((i / 10) % 10), 4'(i % 10)};
      #1;
      check("bcd_to_bin", int'(conv_out), i);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
